hex_display_scheduler: RTL and testbench

Shares the eight on-board seven-segment digits (HEX0–HEX7) among four 32-bit debug sources, such as PC, instruction, ALU result and register value. It keeps one snapshot per source and selects the displayed page either from a debounced pushbutton or from an auto-rotation timer. It decodes the selected snapshot to registered active-low segment outputs. It sits between the processor datapath and the board display pins.

---
 rtl/hex_display_pkg.sv | 35 +++
 rtl/hex_seg_decoder.sv | 32 +++
 rtl/hex_display_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_hex_display_scheduler.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/hex_display_pkg.sv
// Shared constants and types for the hex display scheduler: segment codes,
// key debounce states and source/page sizing.
package hex_display_pkg;

    localparam int PAGE_W  = 2;
    localparam int NUM_SRC = 4;
    localparam int NUM_DIG = 8;

    // Active-low segment patterns, bit order gfedcba
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        K_IDLE,
        K_PRESS,
        K_HELD,
        K_RELEASE
    } key_state_e;

endpackage

// File: rtl/hex_seg_decoder.sv
// Combinational nibble to active-low seven-segment decoder (gfedcba).
module hex_seg_decoder
    import hex_display_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nib)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/hex_display_scheduler.sv
// Pages four 32-bit debug snapshots onto HEX0..HEX7 via debounced key or timer.
// Optional build macro HEX_LEAD_ZERO_BLANK_EN blanks leading zero digits.
module hex_display_scheduler
    import hex_display_pkg::*;
#(
    parameter int ROTATE_CYCLES   = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
)
(
    input  logic               Clock,
    input  logic               Reset,
    input  logic [31:0]        SrcData0,
    input  logic [31:0]        SrcData1,
    input  logic [31:0]        SrcData2,
    input  logic [31:0]        SrcData3,
    input  logic [NUM_SRC-1:0] SrcValid,
    input  logic               KeyNext,
    input  logic               AutoRotate,
    input  logic               Freeze,
    output logic [6:0]         HEX0,
    output logic [6:0]         HEX1,
    output logic [6:0]         HEX2,
    output logic [6:0]         HEX3,
    output logic [6:0]         HEX4,
    output logic [6:0]         HEX5,
    output logic [6:0]         HEX6,
    output logic [6:0]         HEX7,
    output logic [NUM_SRC-1:0] PageLed
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int RW = $clog2(ROTATE_CYCLES);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] ROT_LAST = RW'(ROTATE_CYCLES - 1);

    logic [31:0]        src_data [NUM_SRC];
    logic [31:0]        snap_p0  [NUM_SRC];
    logic [NUM_SRC-1:0] seen_p0;

    assign src_data[0] = SrcData0;
    assign src_data[1] = SrcData1;
    assign src_data[2] = SrcData2;
    assign src_data[3] = SrcData3;

    // Stage p0: snapshot capture, every source independently
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            for (int i = 0; i < NUM_SRC; i++) snap_p0[i] <= '0;
            seen_p0 <= '0;
        end else if (!Freeze) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (SrcValid[i]) begin
                    snap_p0[i] <= src_data[i];
                    seen_p0[i] <= 1'b1;
                end
            end
        end
    end

    logic key_s1, key_s2;
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            key_s1 <= 1'b1;
            key_s2 <= 1'b1;
        end else begin
            key_s1 <= KeyNext;
            key_s2 <= key_s1;
        end
    end

    key_state_e    key_state;
    logic [DW-1:0] deb_cnt;
    logic          press_p;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            key_state <= K_IDLE;
            deb_cnt   <= '0;
            press_p   <= 1'b0;
        end else begin
            press_p <= 1'b0;
            case (key_state)
                K_IDLE: begin
                    deb_cnt <= '0;
                    if (!key_s2) key_state <= K_PRESS;
                end
                K_PRESS: begin
                    if (key_s2) begin
                        key_state <= K_IDLE;
                        deb_cnt   <= '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        key_state <= K_HELD;
                        deb_cnt   <= '0;
                        press_p   <= 1'b1;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                K_HELD: begin
                    deb_cnt <= '0;
                    if (key_s2) key_state <= K_RELEASE;
                end
                K_RELEASE: begin
                    if (!key_s2) begin
                        key_state <= K_HELD;
                        deb_cnt   <= '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        key_state <= K_IDLE;
                        deb_cnt   <= '0;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                default: begin
                    key_state <= K_IDLE;
                    deb_cnt   <= '0;
                end
            endcase
        end
    end

    logic [RW-1:0]     rot_cnt;
    logic [PAGE_W-1:0] page_p0;
    logic              rot_en, timeout, advance;

    assign rot_en  = AutoRotate && !Freeze;
    assign timeout = rot_en && (rot_cnt == ROT_LAST);
    // A press and a timeout landing together still count as one advance
    assign advance = press_p || timeout;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            rot_cnt <= '0;
            page_p0 <= '0;
        end else begin
            if (!rot_en || advance) rot_cnt <= '0;
            else                    rot_cnt <= rot_cnt + 1'b1;
            if (advance) page_p0 <= page_p0 + 1'b1;
        end
    end

    logic [31:0]        sel_snap;
    logic               sel_seen;
    logic [6:0]         dec_seg [NUM_DIG];
    logic [NUM_DIG-1:0] lz_blank;

    assign sel_snap = snap_p0[page_p0];
    assign sel_seen = seen_p0[page_p0];

    for (genvar k = 0; k < NUM_DIG; k++) begin : g_dec
        hex_seg_decoder u_dec (
            .nib (sel_snap[4*k +: 4]),
            .seg (dec_seg[k])
        );
    end

`ifdef HEX_LEAD_ZERO_BLANK_EN
    logic lead_zero;
    // Walk down from HEX7; HEX0 always shows so zero still reads "0"
    always_comb begin
        lz_blank  = '0;
        lead_zero = 1'b1;
        for (int k = NUM_DIG - 1; k >= 1; k--) begin
            if (sel_snap[4*k +: 4] != 4'h0) lead_zero = 1'b0;
            lz_blank[k] = lead_zero;
        end
    end
`else
    assign lz_blank = '0;
`endif

    logic [6:0]         hex_p1 [NUM_DIG];
    logic [NUM_SRC-1:0] led_p1;

    // Stage p1: registered segment and page indicator outputs
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            for (int k = 0; k < NUM_DIG; k++) hex_p1[k] <= SEG_BLANK;
            led_p1 <= NUM_SRC'(1);
        end else begin
            for (int k = 0; k < NUM_DIG; k++)
                hex_p1[k] <= (!sel_seen || lz_blank[k]) ? SEG_BLANK : dec_seg[k];
            led_p1 <= NUM_SRC'(1) << page_p0;
        end
    end

    assign HEX0    = hex_p1[0];
    assign HEX1    = hex_p1[1];
    assign HEX2    = hex_p1[2];
    assign HEX3    = hex_p1[3];
    assign HEX4    = hex_p1[4];
    assign HEX5    = hex_p1[5];
    assign HEX6    = hex_p1[6];
    assign HEX7    = hex_p1[7];
    assign PageLed = led_p1;

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Scoreboard bench for hex_display_scheduler with ROTATE_CYCLES=8, DEBOUNCE_CYCLES=4.
module tb_hex_display_scheduler;

    localparam int ROT = 8;
    localparam int DEB = 4;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [31:0] SrcData0, SrcData1, SrcData2, SrcData3;
    logic [3:0]  SrcValid;
    logic        KeyNext, AutoRotate, Freeze;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;
    logic [3:0]  PageLed;
    logic [55:0] hex_all;

    assign hex_all = {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

    always #5 Clock = ~Clock;

    hex_display_scheduler #(
        .ROTATE_CYCLES   (ROT),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .SrcData0   (SrcData0),
        .SrcData1   (SrcData1),
        .SrcData2   (SrcData2),
        .SrcData3   (SrcData3),
        .SrcValid   (SrcValid),
        .KeyNext    (KeyNext),
        .AutoRotate (AutoRotate),
        .Freeze     (Freeze),
        .HEX0       (HEX0),
        .HEX1       (HEX1),
        .HEX2       (HEX2),
        .HEX3       (HEX3),
        .HEX4       (HEX4),
        .HEX5       (HEX5),
        .HEX6       (HEX6),
        .HEX7       (HEX7),
        .PageLed    (PageLed)
    );

    typedef struct {
        int          due;
        string       name;
        logic [55:0] hex;
        logic [3:0]  led;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always @(posedge Clock) cyc <= cyc + 1;

    function automatic logic [55:0] h8(input logic [6:0] d7, d6, d5, d4, d3, d2, d1, d0);
        return {d7, d6, d5, d4, d3, d2, d1, d0};
    endfunction

    task automatic push(input int dly, input string nm, input logic [55:0] hx, input logic [3:0] ld);
        exp_t e;
        e.due  = cyc + dly;
        e.name = nm;
        e.hex  = hx;
        e.led  = ld;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic press_key();
        KeyNext = 1'b0;
        tick(12);
        KeyNext = 1'b1;
        tick(12);
    endtask

    // Monitor: compares on the falling edge once an expectation falls due
    initial begin
        forever begin
            @(negedge Clock);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                exp_t e;
                e = sb.pop_front();
                n_tests++;
                if (hex_all !== e.hex || PageLed !== e.led) begin
                    n_fail++;
                    $display("FAIL %s: got hex=%h led=%b, expected hex=%h led=%b",
                             e.name, hex_all, PageLed, e.hex, e.led);
                end
            end
        end
    end

    logic [55:0] blank_e, cap0_e, p1_e, p2_e, p3_e;

    initial begin
        blank_e = h8(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        cap0_e  = h8(7'h79, 7'h24, 7'h30, 7'h19, 7'h08, 7'h03, 7'h46, 7'h21);
        p3_e    = h8(7'h21, 7'h06, 7'h08, 7'h21, 7'h03, 7'h06, 7'h06, 7'h0E);
`ifdef HEX_LEAD_ZERO_BLANK_EN
        p1_e    = h8(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h40, 7'h12);
        p2_e    = h8(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40);
`else
        p1_e    = h8(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h08, 7'h40, 7'h12);
        p2_e    = h8(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40);
`endif

        Reset      = 1'b0;
        KeyNext    = 1'b1;
        AutoRotate = 1'b0;
        Freeze     = 1'b0;
        SrcValid   = 4'b0000;
        SrcData0   = '0;
        SrcData1   = '0;
        SrcData2   = '0;
        SrcData3   = '0;

        tick(2);
        push(1, "reset_outputs", blank_e, 4'b0001);
        tick(1);
        Reset = 1'b1;
        push(4, "blank_without_valid", blank_e, 4'b0001);
        tick(5);

        SrcData0 = 32'h1234ABCD;
        SrcData1 = 32'h00000A05;
        SrcData2 = 32'h00000000;
        SrcData3 = 32'hDEADBEEF;
        SrcValid = 4'b1111;
        push(2, "capture_latency", cap0_e, 4'b0001);
        tick(1);
        SrcValid = 4'b0000;
        tick(3);

        Freeze   = 1'b1;
        SrcData0 = 32'hFFFFFFFF;
        SrcData1 = 32'hFFFFFFFF;
        SrcData2 = 32'hFFFFFFFF;
        SrcData3 = 32'hFFFFFFFF;
        SrcValid = 4'b1111;
        push(3, "freeze_blocks_capture", cap0_e, 4'b0001);
        tick(1);
        SrcValid = 4'b0000;
        Freeze   = 1'b0;
        tick(4);

        KeyNext = 1'b0;
        tick(1);
        KeyNext = 1'b1;
        tick(1);
        KeyNext = 1'b0;
        tick(12);
        push(1, "bouncy_key_one_advance", p1_e, 4'b0010);
        push(50, "held_key_no_readvance", p1_e, 4'b0010);
        tick(50);
        KeyNext = 1'b1;
        push(15, "release_no_advance", p1_e, 4'b0010);
        tick(15);

        press_key();
        push(1, "page2_zero_value", p2_e, 4'b0100);
        tick(1);
        press_key();
        push(1, "page3_value", p3_e, 4'b1000);
        tick(2);

        AutoRotate = 1'b1;
        push(7, "autorotate_not_early", p3_e, 4'b1000);
        push(9, "autorotate_wrap_to_0", cap0_e, 4'b0001);
        tick(10);
        AutoRotate = 1'b0;
        tick(2);

        KeyNext    = 1'b0;
        AutoRotate = 1'b1;
        push(10, "press_and_timeout_single", p1_e, 4'b0010);
        tick(11);
        AutoRotate = 1'b0;
        tick(3);
        KeyNext = 1'b1;
        tick(12);

        Freeze     = 1'b1;
        AutoRotate = 1'b1;
        push(20, "freeze_blocks_rotate", p1_e, 4'b0010);
        tick(21);
        AutoRotate = 1'b0;
        Freeze     = 1'b0;
        tick(2);

        KeyNext = 1'b0;
        tick(6);
        Reset   = 1'b0;
        KeyNext = 1'b1;
        push(2, "mid_press_reset_outputs", blank_e, 4'b0001);
        tick(2);
        Reset = 1'b1;
        push(12, "mid_press_reset_no_advance", blank_e, 4'b0001);
        tick(13);

        for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge Clock);
        if (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d checks still pending, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
